spio_hss_multiplexer_reg_access: RTL

Packet-driven initiator for the multiplexer register-bank access port (reg_write / reg_addr / reg_write_data / reg_read_data). It accepts SpiNNaker command packets, checks and decodes them, and performs one register read or write. It then returns a response packet on a valid/ready output. It sits between a local packet source (e.g. a spare channel or the host interface) and the spinnlink register port, so link status can be accessed remotely.

---
 rtl/spio_hss_multiplexer_reg_access_pkg.sv | 34 +++
 rtl/spio_hss_multiplexer_pkt_parity.sv | 12 +
 rtl/spio_hss_multiplexer_reg_access.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spio_hss_multiplexer_reg_access_pkg.sv
// Shared field positions, widths and state encodings for the multiplexer
// register-access initiator.
package spio_hss_multiplexer_reg_access_pkg;

  localparam int PKT_BITS  = 72;
  localparam int REGA_BITS = 5;
  localparam int REGD_BITS = 32;

  localparam int HDR_LO   = 0;
  localparam int KEY_LO   = 8;
  localparam int PLD_LO   = 40;
  localparam int KEY_BITS = 32;
  localparam int PLD_BITS = 32;

  localparam logic [3:0] CMD_TAG_DEF = 4'hE;

  localparam int TAG_HI  = 31;
  localparam int TAG_LO  = 28;
  localparam int WR_BIT  = 27;
  localparam int RSP_BIT = 26;

  localparam int HDR_PLD_BIT = 1;
  localparam int HDR_PAR_BIT = 0;

  localparam int CNT_BITS = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/spio_hss_multiplexer_pkt_parity.sv
// Combinational XOR reduction; result is 1 when the input has an odd
// number of set bits.
module spio_hss_multiplexer_pkt_parity #(
  parameter int W = 72
) (
  input  logic [W-1:0] i_data,
  output logic         o_odd
);

  assign o_odd = ^i_data;

endmodule

// File: rtl/spio_hss_multiplexer_reg_access.sv
// Packet-driven register-bank initiator: decodes one command packet, performs
// a register read or write, and returns an odd-parity response packet.
module spio_hss_multiplexer_reg_access
  import spio_hss_multiplexer_reg_access_pkg::*;
#(
  parameter logic [3:0] CMD_TAG = CMD_TAG_DEF,
  parameter int         RD_LAT  = 1,
  parameter bit         ACK_WR  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PKT_BITS-1:0]  cmd_data,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic [PKT_BITS-1:0]  rsp_data,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic                 reg_write,
  output logic [REGA_BITS-1:0] reg_addr,
  output logic [REGD_BITS-1:0] reg_write_data,
  input  logic [REGD_BITS-1:0] reg_read_data,
  output logic [7:0]           drop_cnt,
  output logic                 busy
);

  state_t                r_state, w_nxt;
  logic [KEY_BITS-1:0]   r_key;
  logic [5:0]            r_hdr_hi;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [REGA_BITS-1:0]  r_addr;
  logic [REGD_BITS-1:0]  r_wdata;
  logic [PKT_BITS-1:0]   r_rsp;
  logic [7:0]            r_drop;

  logic [7:0]            w_hdr;
  logic [KEY_BITS-1:0]   w_key;
  logic [PLD_BITS-1:0]   w_pld;
  logic                  w_in_odd, w_ok, w_acc;
  logic                  w_is_rd;
  logic [KEY_BITS-1:0]   w_rsp_key;
  logic [PLD_BITS-1:0]   w_rsp_pld;
  logic [PKT_BITS-1:0]   w_rsp_body;
  logic                  w_rsp_odd;

  assign w_hdr = cmd_data[HDR_LO +: 8];
  assign w_key = cmd_data[KEY_LO +: KEY_BITS];
  assign w_pld = cmd_data[PLD_LO +: PLD_BITS];

  spio_hss_multiplexer_pkt_parity #(.W(PKT_BITS)) u_in_par (
    .i_data (cmd_data),
    .o_odd  (w_in_odd)
  );

  assign w_ok = w_in_odd
             && (w_key[TAG_HI:TAG_LO] == CMD_TAG)
             && (!w_key[WR_BIT] || w_hdr[HDR_PLD_BIT]);

  // Held low during reset so nothing is accepted while the block is cleared.
  assign cmd_rdy = (r_state == S_IDLE) && !rst;
  assign w_acc   = cmd_vld && cmd_rdy;

  // Response body is built with header[0]=0; its XOR then fixes the parity bit.
  assign w_is_rd   = (r_state == S_READ);
  assign w_rsp_key = r_key | (KEY_BITS'(1) << RSP_BIT);
  assign w_rsp_pld = w_is_rd ? reg_read_data : '0;
  assign w_rsp_body = {w_rsp_pld, w_rsp_key, r_hdr_hi, w_is_rd, 1'b0};

  spio_hss_multiplexer_pkt_parity #(.W(PKT_BITS)) u_out_par (
    .i_data (w_rsp_body),
    .o_odd  (w_rsp_odd)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc && w_ok) w_nxt = w_key[WR_BIT] ? S_WRITE : S_READ;
      S_WRITE: w_nxt = ACK_WR ? S_RESP : S_IDLE;
      S_READ:  if (r_cnt == '0) w_nxt = S_RESP;
      S_RESP:  if (rsp_rdy) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_hdr_hi <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rsp    <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        if (w_ok) begin
          r_key    <= w_key;
          r_hdr_hi <= w_hdr[7:2];
          r_addr   <= w_key[REGA_BITS-1:0];
          r_cnt    <= CNT_BITS'(RD_LAT - 1);
          if (w_key[WR_BIT]) r_wdata <= w_pld;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end
      if (w_is_rd && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_nxt == S_RESP && r_state != S_RESP)
        r_rsp <= {w_rsp_body[PKT_BITS-1:1], ~w_rsp_odd};
    end
  end

  // Strobe decoded from state so an async reset clears it immediately.
  assign reg_write      = (r_state == S_WRITE);
  assign reg_addr       = r_addr;
  assign reg_write_data = r_wdata;
  assign rsp_vld        = (r_state == S_RESP);
  assign rsp_data       = r_rsp;
  assign drop_cnt       = r_drop;
  assign busy           = (r_state != S_IDLE);

endmodule
